// File: rtl/imsic_access_arbiter_if.sv
// Bundle of requester-side and IMSIC-side signals for the IMSIC access arbiter.
// slave = arbiter view, master = requesters/IMSIC view.
interface imsic_access_arbiter_if #(
  parameter int NrReq  = 2,
  parameter int XLEN   = 64,
  parameter int VgeinW = 6
);
  logic [NrReq-1:0]        req_valid_i;
  logic [NrReq-1:0]        req_ready_o;
  logic [NrReq-1:0]        req_we_i;
  logic [NrReq-1:0]        req_claim_i;
  logic [NrReq*XLEN-1:0]   req_addr_i;
  logic [NrReq*XLEN-1:0]   req_data_i;
  logic [NrReq*2-1:0]      req_priv_i;
  logic [NrReq*VgeinW-1:0] req_vgein_i;

  logic [NrReq-1:0]        rsp_valid_o;
  logic [XLEN-1:0]         rsp_data_o;
  logic                    rsp_exc_o;

  logic                    imsic_we_o;
  logic                    imsic_claim_o;
  logic [XLEN-1:0]         imsic_addr_o;
  logic [XLEN-1:0]         imsic_data_o;
  logic [1:0]              imsic_priv_lvl_o;
  logic [VgeinW-1:0]       imsic_vgein_o;
  logic [XLEN-1:0]         imsic_data_i;
  logic                    imsic_exception_i;

  modport slave (
    input  req_valid_i, req_we_i, req_claim_i, req_addr_i, req_data_i,
           req_priv_i, req_vgein_i, imsic_data_i, imsic_exception_i,
    output req_ready_o, rsp_valid_o, rsp_data_o, rsp_exc_o,
           imsic_we_o, imsic_claim_o, imsic_addr_o, imsic_data_o,
           imsic_priv_lvl_o, imsic_vgein_o
  );

  modport master (
    output req_valid_i, req_we_i, req_claim_i, req_addr_i, req_data_i,
           req_priv_i, req_vgein_i, imsic_data_i, imsic_exception_i,
    input  req_ready_o, rsp_valid_o, rsp_data_o, rsp_exc_o,
           imsic_we_o, imsic_claim_o, imsic_addr_o, imsic_data_o,
           imsic_priv_lvl_o, imsic_vgein_o
  );
endinterface

// File: rtl/imsic_access_arbiter.sv
// Shares the per-hart IMSIC register-access port among NrReq requesters, one access in flight.
// Round-robin by default; define IMSIC_ARB_FIXED_PRIO_EN for fixed lowest-index-wins priority.
//
// state | meaning
// IDLE  | arbitrate, capture winning request on handshake
// ISSUE | one-cycle IMSIC strobe, load latency counter
// WAIT  | count down remaining IMSIC read latency
// RESP  | return IMSIC data/exception to the owner for one cycle
module imsic_access_arbiter #(
  parameter int NrReq     = 2,
  parameter int XLEN      = 64,
  parameter int VgeinW    = 6,
  parameter int RdLatency = 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  imsic_access_arbiter_if.slave bus
);
  localparam int IdxW = (NrReq > 1) ? $clog2(NrReq) : 1;
  localparam int CntW = (RdLatency > 1) ? $clog2(RdLatency) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [IdxW-1:0]   owner_q, owner_d;
  logic              we_q, we_d;
  logic              claim_q, claim_d;
  logic [XLEN-1:0]   addr_q, addr_d;
  logic [XLEN-1:0]   data_q, data_d;
  logic [1:0]        priv_q, priv_d;
  logic [VgeinW-1:0] vgein_q, vgein_d;

  logic [NrReq-1:0]  grant;
  logic [IdxW-1:0]   grant_idx;
  logic              grant_any;
  logic              capture;

  logic [XLEN-1:0]   addr_arr  [NrReq];
  logic [XLEN-1:0]   data_arr  [NrReq];
  logic [1:0]        priv_arr  [NrReq];
  logic [VgeinW-1:0] vgein_arr [NrReq];

  for (genvar g = 0; g < NrReq; g++) begin : g_unpack
    assign addr_arr[g]  = bus.req_addr_i[g*XLEN +: XLEN];
    assign data_arr[g]  = bus.req_data_i[g*XLEN +: XLEN];
    assign priv_arr[g]  = bus.req_priv_i[g*2 +: 2];
    assign vgein_arr[g] = bus.req_vgein_i[g*VgeinW +: VgeinW];
  end

`ifdef IMSIC_ARB_FIXED_PRIO_EN
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    for (int k = 0; k < NrReq; k++) begin
      if (!grant_any && bus.req_valid_i[k]) begin
        grant_any = 1'b1;
        grant[k]  = 1'b1;
        grant_idx = IdxW'(k);
      end
    end
  end
`else
  logic [IdxW-1:0] rr_q, rr_d;

  // search starts at the pointer and wraps past the last requester
  always_comb begin
    int idx;
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    idx       = 0;
    for (int k = 0; k < NrReq; k++) begin
      idx = int'(rr_q) + k;
      if (idx >= NrReq) idx = idx - NrReq;
      if (!grant_any && bus.req_valid_i[idx]) begin
        grant_any   = 1'b1;
        grant[idx]  = 1'b1;
        grant_idx   = IdxW'(idx);
      end
    end
  end

  always_comb begin
    rr_d = rr_q;
    if (capture) begin
      rr_d = (grant_idx == IdxW'(NrReq - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) rr_q <= '0;
    else       rr_q <= rr_d;
  end
`endif

  assign capture = (state_q == IDLE) && grant_any;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE:  if (grant_any) state_d = ISSUE;
      ISSUE: begin
        cnt_d   = CntW'(RdLatency - 1);
        state_d = (RdLatency == 1) ? RESP : WAIT;
      end
      WAIT: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_d == '0) state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // captured copy is what the IMSIC sees; later requester changes are ignored
  always_comb begin
    owner_d = owner_q;
    we_d    = we_q;
    claim_d = claim_q;
    addr_d  = addr_q;
    data_d  = data_q;
    priv_d  = priv_q;
    vgein_d = vgein_q;
    if (capture) begin
      owner_d = grant_idx;
      we_d    = bus.req_we_i[grant_idx];
      claim_d = bus.req_claim_i[grant_idx];
      addr_d  = addr_arr[grant_idx];
      data_d  = data_arr[grant_idx];
      priv_d  = priv_arr[grant_idx];
      vgein_d = vgein_arr[grant_idx];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      owner_q <= '0;
      we_q    <= 1'b0;
      claim_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      priv_q  <= '0;
      vgein_q <= '0;
    end else begin
      owner_q <= owner_d;
      we_q    <= we_d;
      claim_q <= claim_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      priv_q  <= priv_d;
      vgein_q <= vgein_d;
    end
  end

  // outputs are forced low while reset is asserted so an aborted access never strobes or responds
  always_comb begin
    bus.req_ready_o      = '0;
    bus.rsp_valid_o      = '0;
    bus.rsp_data_o       = '0;
    bus.rsp_exc_o        = 1'b0;
    bus.imsic_we_o       = 1'b0;
    bus.imsic_claim_o    = 1'b0;
    bus.imsic_addr_o     = '0;
    bus.imsic_data_o     = '0;
    bus.imsic_priv_lvl_o = '0;
    bus.imsic_vgein_o    = '0;
    if (!rst_i) begin
      if (state_q == IDLE) begin
        bus.req_ready_o = grant;
      end else begin
        bus.imsic_addr_o     = addr_q;
        bus.imsic_data_o     = data_q;
        bus.imsic_priv_lvl_o = priv_q;
        bus.imsic_vgein_o    = vgein_q;
      end
      if (state_q == ISSUE) begin
        bus.imsic_we_o    = we_q & ~claim_q;
        bus.imsic_claim_o = claim_q;
      end
      if (state_q == RESP) begin
        bus.rsp_valid_o[owner_q] = 1'b1;
        bus.rsp_exc_o            = bus.imsic_exception_i;
        bus.rsp_data_o           = (bus.imsic_exception_i || (we_q && !claim_q))
                                   ? '0 : bus.imsic_data_i;
      end
    end
  end
endmodule

// File: tb/tb_imsic_access_arbiter.sv
// Self-checking bench for imsic_access_arbiter: directed scenarios plus randomized traffic
// checked every cycle against a transaction-level model.
module tb_imsic_access_arbiter;
  localparam int NR     = 2;
  localparam int XLEN   = 64;
  localparam int VG     = 6;
  localparam int RD_LAT = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  imsic_access_arbiter_if #(.NrReq(NR), .XLEN(XLEN), .VgeinW(VG)) bus ();

  imsic_access_arbiter #(.NrReq(NR), .XLEN(XLEN), .VgeinW(VG), .RdLatency(RD_LAT)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // transaction-level model: an access occupies RD_LAT+1 cycles after its handshake
  logic              m_busy = 1'b0;
  int                m_age = 0;
  int                m_owner = 0;
  int                m_rr = 0;
  logic              m_we, m_claim;
  logic [XLEN-1:0]   m_addr, m_data;
  logic [1:0]        m_priv;
  logic [VG-1:0]     m_vg;

  function automatic int pick(input logic [NR-1:0] v, input int start);
    for (int k = 0; k < NR; k++) begin
      int i;
      i = (start + k) % NR;
      if (v[i]) return i;
    end
    return -1;
  endfunction

  always @(negedge clk) begin : cmp
    logic [NR-1:0]   e_ready, e_rspv;
    logic            e_iwe, e_icl, e_exc;
    logic [XLEN-1:0] e_iaddr, e_idata, e_rdata;
    logic [1:0]      e_priv;
    logic [VG-1:0]   e_vg;
    int              g;
    e_ready = '0; e_rspv = '0; e_iwe = 1'b0; e_icl = 1'b0; e_exc = 1'b0;
    e_iaddr = '0; e_idata = '0; e_rdata = '0; e_priv = '0; e_vg = '0;
    g = -1;
    if (!rst) begin
      if (!m_busy) begin
`ifdef IMSIC_ARB_FIXED_PRIO_EN
        g = pick(bus.req_valid_i, 0);
`else
        g = pick(bus.req_valid_i, m_rr);
`endif
        if (g >= 0) e_ready[g] = 1'b1;
      end else begin
        e_iaddr = m_addr; e_idata = m_data; e_priv = m_priv; e_vg = m_vg;
        if (m_age == 1) begin
          e_iwe = m_we && !m_claim;
          e_icl = m_claim;
        end
        if (m_age == RD_LAT + 1) begin
          e_rspv[m_owner] = 1'b1;
          e_exc   = bus.imsic_exception_i;
          e_rdata = (bus.imsic_exception_i || (m_we && !m_claim)) ? '0 : bus.imsic_data_i;
        end
      end
    end
    chk("req_ready",   XLEN'(bus.req_ready_o),      XLEN'(e_ready));
    chk("rsp_valid",   XLEN'(bus.rsp_valid_o),      XLEN'(e_rspv));
    chk("rsp_data",    bus.rsp_data_o,              e_rdata);
    chk("rsp_exc",     XLEN'(bus.rsp_exc_o),        XLEN'(e_exc));
    chk("imsic_we",    XLEN'(bus.imsic_we_o),       XLEN'(e_iwe));
    chk("imsic_claim", XLEN'(bus.imsic_claim_o),    XLEN'(e_icl));
    chk("imsic_addr",  bus.imsic_addr_o,            e_iaddr);
    chk("imsic_data",  bus.imsic_data_o,            e_idata);
    chk("imsic_priv",  XLEN'(bus.imsic_priv_lvl_o), XLEN'(e_priv));
    chk("imsic_vgein", XLEN'(bus.imsic_vgein_o),    XLEN'(e_vg));
    // advance the model across the coming rising edge (inputs are stable until then)
    if (rst) begin
      m_busy = 1'b0;
      m_rr   = 0;
    end else if (!m_busy) begin
      if (g >= 0) begin
        m_busy  = 1'b1;
        m_age   = 1;
        m_owner = g;
        m_we    = bus.req_we_i[g];
        m_claim = bus.req_claim_i[g];
        m_addr  = bus.req_addr_i[g*XLEN +: XLEN];
        m_data  = bus.req_data_i[g*XLEN +: XLEN];
        m_priv  = bus.req_priv_i[g*2 +: 2];
        m_vg    = bus.req_vgein_i[g*VG +: VG];
        m_rr    = (g + 1) % NR;
      end
    end else if (m_age == RD_LAT + 1) begin
      m_busy = 1'b0;
    end else begin
      m_age++;
    end
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    bus.req_valid_i = '0; bus.req_we_i = '0; bus.req_claim_i = '0;
    bus.req_addr_i = '0; bus.req_data_i = '0; bus.req_priv_i = '0; bus.req_vgein_i = '0;
    bus.imsic_data_i = '0; bus.imsic_exception_i = 1'b0;
  endtask

  task automatic do_access(input int idx, input logic we, input logic claim,
                           input logic [XLEN-1:0] addr, input logic [XLEN-1:0] rdata,
                           input logic exc, output logic ok, output int lat,
                           output logic [XLEN-1:0] rsp_d, output logic rsp_e,
                           output logic iss_we, output logic iss_claim,
                           output logic [XLEN-1:0] iss_addr);
    int n;
    ok = 1'b0; lat = 0; rsp_d = '0; rsp_e = 1'b0;
    iss_we = 1'b0; iss_claim = 1'b0; iss_addr = '0;
    bus.req_valid_i[idx] = 1'b1;
    bus.req_we_i[idx]    = we;
    bus.req_claim_i[idx] = claim;
    bus.req_addr_i[idx*XLEN +: XLEN] = addr;
    bus.req_data_i[idx*XLEN +: XLEN] = addr ^ 64'h1234_5678_9ABC_DEF0;
    bus.req_priv_i[idx*2 +: 2]       = 2'd3;
    bus.req_vgein_i[idx*VG +: VG]    = VG'(idx + 5);
    bus.imsic_data_i      = rdata;
    bus.imsic_exception_i = exc;
    n = 0;
    @(negedge clk);
    while (!bus.req_ready_o[idx] && n < 20) begin
      step();
      @(negedge clk);
      n++;
    end
    if (!bus.req_ready_o[idx]) begin
      chk("grant_wait", XLEN'(bus.req_ready_o[idx]), XLEN'(1));
      bus.req_valid_i[idx] = 1'b0;
      step();
      return;
    end
    step();
    bus.req_valid_i[idx] = 1'b0;
    @(negedge clk);
    iss_we = bus.imsic_we_o; iss_claim = bus.imsic_claim_o; iss_addr = bus.imsic_addr_o;
    lat = 1;
    while (!bus.rsp_valid_o[idx] && lat < 20) begin
      step();
      @(negedge clk);
      lat++;
    end
    if (bus.rsp_valid_o[idx]) begin
      ok = 1'b1; rsp_d = bus.rsp_data_o; rsp_e = bus.rsp_exc_o;
    end
    step();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic            ok, re, iwe, icl, seen;
    logic [XLEN-1:0] rd, ia;
    int              lat, ng;
    int              gseq [4];
    int              gexp [4];

    // reset with every requester asking
    idle_inputs();
    rst = 1'b1;
    bus.req_valid_i = '1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("reset_ready",   XLEN'(bus.req_ready_o), '0);
      chk("reset_imsic_we", XLEN'(bus.imsic_we_o), '0);
      chk("reset_addr",    bus.imsic_addr_o, '0);
      step();
    end
    rst = 1'b0;
    idle_inputs();
    step();

    // single read
    do_access(0, 1'b0, 1'b0, 64'h70, 64'hDEAD, 1'b0, ok, lat, rd, re, iwe, icl, ia);
    chk("read_rsp_seen", XLEN'(ok), XLEN'(1));
    chk("read_latency",  XLEN'(lat), XLEN'(RD_LAT + 1));
    chk("read_addr",     ia, 64'h70);
    chk("read_data",     rd, 64'hDEAD);
    chk("read_exc",      XLEN'(re), '0);

    // contention from a fresh pointer
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    bus.req_valid_i = '1;
    ng = 0;
    for (int k = 0; k < 4; k++) begin
      gseq[k] = -1;
`ifdef IMSIC_ARB_FIXED_PRIO_EN
      gexp[k] = 0;
`else
      gexp[k] = k % 2;
`endif
    end
    for (int c = 0; c < 60 && ng < 4; c++) begin
      @(negedge clk);
      if (bus.req_ready_o != '0) begin
        gseq[ng] = bus.req_ready_o[1] ? 1 : 0;
        ng++;
      end
      step();
    end
    bus.req_valid_i = '0;
    chk("contention_count", XLEN'(ng), XLEN'(4));
    for (int k = 0; k < 4; k++) chk($sformatf("contention_grant%0d", k), XLEN'(gseq[k]), XLEN'(gexp[k]));
    for (int k = 0; k < RD_LAT + 2; k++) step();

    // claim wins over write, returns topei
    do_access(1, 1'b1, 1'b1, 64'h0000_0070, 64'h002A_002A, 1'b0, ok, lat, rd, re, iwe, icl, ia);
    chk("claim_rsp_seen", XLEN'(ok), XLEN'(1));
    chk("claim_strobe",   XLEN'(icl), XLEN'(1));
    chk("claim_no_we",    XLEN'(iwe), '0);
    chk("claim_topei",    rd, 64'h002A_002A);

    // pure write returns zero data
    do_access(0, 1'b1, 1'b0, 64'h0000_0080, 64'h7777, 1'b0, ok, lat, rd, re, iwe, icl, ia);
    chk("write_we",   XLEN'(iwe), XLEN'(1));
    chk("write_data", rd, '0);

    // faulting access
    do_access(0, 1'b0, 1'b0, 64'h0000_00FF, 64'h55, 1'b1, ok, lat, rd, re, iwe, icl, ia);
    chk("exc_rsp_seen", XLEN'(ok), XLEN'(1));
    chk("exc_flag",     XLEN'(re), XLEN'(1));
    chk("exc_data",     rd, '0);

    // reset while waiting on the IMSIC
    idle_inputs();
    bus.req_valid_i[0] = 1'b1;
    bus.req_addr_i[0 +: XLEN] = 64'h80;
    ng = 0;
    @(negedge clk);
    while (!bus.req_ready_o[0] && ng < 20) begin
      step();
      @(negedge clk);
      ng++;
    end
    chk("rstmid_grant", XLEN'(bus.req_ready_o[0]), XLEN'(1));
    step();
    bus.req_valid_i[0] = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < RD_LAT + 3; k++) begin
      @(negedge clk);
      if (bus.rsp_valid_o != '0) seen = 1'b1;
      step();
    end
    chk("rstmid_no_rsp", XLEN'(seen), '0);
    do_access(1, 1'b0, 1'b0, 64'h90, 64'hCAFE, 1'b0, ok, lat, rd, re, iwe, icl, ia);
    chk("rstmid_next_seen", XLEN'(ok), XLEN'(1));
    chk("rstmid_next_data", rd, 64'hCAFE);

    // randomized traffic, including occasional resets
    for (int c = 0; c < 2000; c++) begin
      rst = ($urandom_range(199) == 0);
      for (int i = 0; i < NR; i++) begin
        bus.req_valid_i[i] = ($urandom_range(99) < 55);
        bus.req_we_i[i]    = 1'($urandom_range(1));
        bus.req_claim_i[i] = ($urandom_range(3) == 0);
        bus.req_addr_i[i*XLEN +: XLEN] = {$urandom, $urandom};
        bus.req_data_i[i*XLEN +: XLEN] = {$urandom, $urandom};
        bus.req_priv_i[i*2 +: 2]       = 2'($urandom_range(3));
        bus.req_vgein_i[i*VG +: VG]    = VG'($urandom);
      end
      bus.imsic_data_i      = {$urandom, $urandom};
      bus.imsic_exception_i = ($urandom_range(4) == 0);
      step();
    end
    rst = 1'b0;
    idle_inputs();
    step();
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
